nfc_status_poller: RTL and testbench



---
 rtl/nfc_status_poller_if.sv | 55 +++++
 rtl/nfc_status_poller.sv | 161 ++++++++++++++++
 tb/tb_nfc_status_poller.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_status_poller_if.sv
`default_nettype none
// ============================================================================
//  Module   : nfc_status_poller_if
//  Purpose  : Request, command-engine, read-stream and result bundle for the
//             NAND read-status poller.
//  Revision : 1.0
// ============================================================================
interface nfc_status_poller_if #(
    parameter int NumberOfWays = 4
);
    logic                    iPollValid;
    logic                    oPollReady;
    logic [NumberOfWays-1:0] iPollWay;
    logic [23:0]             iPollRowAddress;
    logic                    iPollEnhanced;

    logic [5:0]              oOpcode;
    logic [4:0]              oTargetID;
    logic                    oCMDValid;
    logic                    iCMDReady;
    logic [NumberOfWays-1:0] oWaySelect;
    logic [23:0]             oRowAddress;
    logic                    iLastStep;

    logic [15:0]             iReadData;
    logic                    iReadValid;
    logic                    iReadLast;
    logic                    oReadReady;

    logic                    oResultValid;
    logic [NumberOfWays-1:0] oResultWay;
    logic [7:0]              oStatus;
    logic                    oResultFail;
    logic                    oResultTimeout;
    logic [7:0]              oPollCount;

    // Poller side
    modport master (
        input  iPollValid, iPollWay, iPollRowAddress, iPollEnhanced,
        input  iCMDReady, iLastStep, iReadData, iReadValid, iReadLast,
        output oPollReady, oOpcode, oTargetID, oCMDValid, oWaySelect, oRowAddress,
        output oReadReady, oResultValid, oResultWay, oStatus, oResultFail,
        output oResultTimeout, oPollCount
    );

    // Controller / command-engine side
    modport slave (
        output iPollValid, iPollWay, iPollRowAddress, iPollEnhanced,
        output iCMDReady, iLastStep, iReadData, iReadValid, iReadLast,
        input  oPollReady, oOpcode, oTargetID, oCMDValid, oWaySelect, oRowAddress,
        input  oReadReady, oResultValid, oResultWay, oStatus, oResultFail,
        input  oResultTimeout, oPollCount
    );
endinterface
`default_nettype wire

// File: rtl/nfc_status_poller.sv
`default_nettype none
// ============================================================================
//  Module   : nfc_status_poller
//  Purpose  : Issues 70h/78h read-status polls after program/erase and reports
//             ready/fail or timeout. Optional macro NFC_STATUS_POLL_ARRAY_READY_EN
//             additionally requires ARDY (status bit 5) for ready.
//  Revision : 1.0
// ============================================================================
module nfc_status_poller #(
    parameter int         NumberOfWays = 4,
    parameter logic [5:0] CommandID    = 6'b000111,
    parameter logic [4:0] TargetID     = 5'b00101,
    parameter int         MaxPolls     = 16,
    parameter int         PollGap      = 32
) (
    input  wire logic           iSystemClock,
    input  wire logic           iReset,
    nfc_status_poller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_GAP    = 3'd4,
        S_REPORT = 3'd5
    } pollState_t;

    localparam logic [7:0]  c_MAX_POLLS = 8'(MaxPolls);
    localparam logic [15:0] c_GAP_LOAD  = 16'(PollGap - 1);

    pollState_t              r_state;
    pollState_t              w_nextState;
    logic [NumberOfWays-1:0] r_way;
    logic [23:0]             r_row;
    logic                    r_enhanced;
    logic [7:0]              r_status;
    logic                    r_captured;
    logic [7:0]              r_pollCount;
    logic [15:0]             r_gapCount;
    logic                    r_fail;
    logic                    r_timeout;

    logic                    w_accept;
    logic                    w_ready;
    logic                    w_unusedBits;

    assign w_accept     = bus.iPollValid && (r_state == S_IDLE);
    assign w_unusedBits = ^{bus.iReadData[15:8], bus.iReadLast};

`ifdef NFC_STATUS_POLL_ARRAY_READY_EN
    assign w_ready = r_status[6] & r_status[5];
`else
    assign w_ready = r_status[6];
`endif

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)      w_nextState = S_ISSUE;
            S_ISSUE:  if (bus.iCMDReady) w_nextState = S_WAIT;
            S_WAIT:   if (bus.iLastStep) w_nextState = S_EVAL;
            S_EVAL: begin
                if (w_ready || (r_pollCount == c_MAX_POLLS)) begin
                    w_nextState = S_REPORT;
                end else begin
                    w_nextState = S_GAP;
                end
            end
            S_GAP:    if (r_gapCount == 16'd0) w_nextState = S_ISSUE;
            S_REPORT: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_way       <= '0;
            r_row       <= 24'd0;
            r_enhanced  <= 1'b0;
            r_status    <= 8'd0;
            r_captured  <= 1'b0;
            r_pollCount <= 8'd0;
            r_gapCount  <= 16'd0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_way       <= bus.iPollWay;
                        r_row       <= bus.iPollRowAddress;
                        r_enhanced  <= bus.iPollEnhanced;
                        r_pollCount <= 8'd0;
                        r_status    <= 8'd0;
                        r_fail      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (bus.iCMDReady) begin
                        r_pollCount <= r_pollCount + 8'd1;
                        r_captured  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Only the first beat of a poll carries the status; a poll
                    // that ends with no beat at all reads as not ready.
                    if (bus.iReadValid && !r_captured) begin
                        r_status   <= bus.iReadData[7:0];
                        r_captured <= 1'b1;
                    end else if (bus.iLastStep && !r_captured) begin
                        r_status <= 8'h00;
                    end
                end
                S_EVAL: begin
                    if (w_ready) begin
                        r_fail    <= r_status[0];
                        r_timeout <= 1'b0;
                    end else if (r_pollCount == c_MAX_POLLS) begin
                        r_fail    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_gapCount <= c_GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (r_gapCount != 16'd0) begin
                        r_gapCount <= r_gapCount - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oPollReady     = (r_state == S_IDLE);
    assign bus.oOpcode        = CommandID;
    assign bus.oTargetID      = {TargetID[4:1], r_enhanced};
    assign bus.oCMDValid      = (r_state == S_ISSUE);
    assign bus.oWaySelect     = r_way;
    assign bus.oRowAddress    = r_row;
    assign bus.oReadReady     = (r_state == S_WAIT);
    assign bus.oResultValid   = (r_state == S_REPORT);
    assign bus.oResultWay     = r_way;
    assign bus.oStatus        = r_status;
    assign bus.oResultFail    = r_fail;
    assign bus.oResultTimeout = r_timeout;
    assign bus.oPollCount     = r_pollCount;

endmodule
`default_nettype wire

// File: tb/tb_nfc_status_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nfc_status_poller
//  Purpose  : Scoreboard bench with an engine model and a poll-outcome model.
//  Revision : 1.0
// ============================================================================
module tb_nfc_status_poller;

    localparam int         c_WAYS      = 4;
    localparam int         c_MAX_POLLS = 4;
    localparam int         c_POLL_GAP  = 3;
    localparam logic [5:0] c_CMD_ID    = 6'b000111;
    localparam logic [4:0] c_TGT_ID    = 5'b00101;

    logic iSystemClock = 1'b0;
    logic iReset       = 1'b1;

    nfc_status_poller_if #(.NumberOfWays(c_WAYS)) bus ();

    nfc_status_poller #(
        .NumberOfWays(c_WAYS),
        .CommandID   (c_CMD_ID),
        .TargetID    (c_TGT_ID),
        .MaxPolls    (c_MAX_POLLS),
        .PollGap     (c_POLL_GAP)
    ) dut (
        .iSystemClock(iSystemClock),
        .iReset      (iReset),
        .bus         (bus)
    );

    always #5 iSystemClock = ~iSystemClock;

    typedef struct {
        int         nBeats;
        logic [7:0] b0;
        logic [7:0] b1;
        int         readyDelay;
        int         latency;
        bit         coincide;
    } resp_t;

    typedef struct {
        logic [c_WAYS-1:0] way;
        logic [23:0]       row;
        logic [4:0]        tgt;
    } cmd_t;

    typedef struct {
        logic [c_WAYS-1:0] way;
        logic [7:0]        status;
        logic              fail;
        logic              timeout;
        logic [7:0]        count;
    } res_t;

    resp_t respQ[$];
    cmd_t  cmdQ[$];
    res_t  resQ[$];
    resp_t plan[$];

    int nChecks     = 0;
    int nFails      = 0;
    int lastStepSeen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit isReady(input logic [7:0] s);
`ifdef NFC_STATUS_POLL_ARRAY_READY_EN
        return s[6] && s[5];
`else
        return s[6];
`endif
    endfunction

    function automatic resp_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                 input int rd, input int lat, input bit co);
        resp_t r;
        r.nBeats = n; r.b0 = b0; r.b1 = b1; r.readyDelay = rd; r.latency = lat; r.coincide = co;
        return r;
    endfunction

    // ---------------- command engine model ----------------
    initial begin : engine
        resp_t e;
        bit    lastSent;
        bus.iCMDReady  = 1'b0;
        bus.iLastStep  = 1'b0;
        bus.iReadData  = 16'd0;
        bus.iReadValid = 1'b0;
        bus.iReadLast  = 1'b0;
        forever begin
            @(posedge iSystemClock); #1;
            if (bus.oCMDValid && !iReset) begin
                if (respQ.size() != 0) e = respQ[0];
                else                   e = mk(1, 8'h40, 8'h00, 0, 0, 1'b0);
                repeat (e.readyDelay) begin @(posedge iSystemClock); #1; end
                bus.iCMDReady = 1'b1;
                @(posedge iSystemClock); #1;
                bus.iCMDReady = 1'b0;
                if (respQ.size() != 0) void'(respQ.pop_front());
                repeat (e.latency) begin @(posedge iSystemClock); #1; end
                lastSent = 1'b0;
                for (int b = 0; b < e.nBeats; b++) begin
                    bus.iReadValid = 1'b1;
                    bus.iReadData  = {8'($urandom), (b == 0) ? e.b0 : e.b1};
                    bus.iReadLast  = (b == e.nBeats - 1);
                    if ((b == e.nBeats - 1) && e.coincide) begin
                        bus.iLastStep = 1'b1;
                        lastSent      = 1'b1;
                    end
                    @(posedge iSystemClock); #1;
                end
                bus.iReadValid = 1'b0;
                bus.iReadLast  = 1'b0;
                if (!lastSent) begin
                    bus.iLastStep = 1'b1;
                    @(posedge iSystemClock); #1;
                end
                bus.iLastStep = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic              prevStall    = 1'b0;
    logic              prevCmdValid = 1'b0;
    logic [c_WAYS-1:0] prevWay      = '0;
    logic [23:0]       prevRow      = 24'd0;
    int                cyc          = 0;
    int                lastStepCyc  = -1;

    always @(negedge iSystemClock) begin : monitor
        cmd_t ec;
        res_t er;
        cyc++;
        if (iReset) begin
            prevStall    = 1'b0;
            prevCmdValid = 1'b0;
            lastStepCyc  = -1;
        end else begin
            if (prevStall) begin
                check("cmd_hold_valid", 32'(bus.oCMDValid), 32'd1);
                check("cmd_hold_way",   32'(bus.oWaySelect), 32'(prevWay));
                check("cmd_hold_row",   32'(bus.oRowAddress), 32'(prevRow));
            end
            if (bus.oCMDValid && !prevCmdValid && (lastStepCyc >= 0)) begin
                check("poll_gap_cycles", 32'(cyc - lastStepCyc), 32'(c_POLL_GAP + 2));
                lastStepCyc = -1;
            end
            if (bus.oCMDValid && bus.iCMDReady) begin
                if (cmdQ.size() == 0) begin
                    nChecks++; nFails++;
                    $display("FAIL unexpected_cmd: got command with way %0h, expected none", bus.oWaySelect);
                end else begin
                    ec = cmdQ.pop_front();
                    check("cmd_way",    32'(bus.oWaySelect), 32'(ec.way));
                    check("cmd_row",    32'(bus.oRowAddress), 32'(ec.row));
                    check("cmd_target", 32'(bus.oTargetID), 32'(ec.tgt));
                    check("cmd_opcode", 32'(bus.oOpcode), 32'(c_CMD_ID));
                end
            end
            if (bus.iReadValid) check("read_ready", 32'(bus.oReadReady), 32'd1);
            if (bus.iLastStep) begin
                lastStepCyc = cyc;
                lastStepSeen++;
            end
            if (bus.iPollValid && bus.oPollReady) lastStepCyc = -1;
            if (bus.oResultValid) begin
                if (resQ.size() == 0) begin
                    nChecks++; nFails++;
                    $display("FAIL unexpected_result: got result for way %0h, expected none", bus.oResultWay);
                end else begin
                    er = resQ.pop_front();
                    check("res_way",     32'(bus.oResultWay), 32'(er.way));
                    check("res_status",  32'(bus.oStatus), 32'(er.status));
                    check("res_fail",    32'(bus.oResultFail), 32'(er.fail));
                    check("res_timeout", 32'(bus.oResultTimeout), 32'(er.timeout));
                    check("res_count",   32'(bus.oPollCount), 32'(er.count));
                end
            end
        end
        prevStall    = bus.oCMDValid && !bus.iCMDReady && !iReset;
        prevCmdValid = bus.oCMDValid;
        prevWay      = bus.oWaySelect;
        prevRow      = bus.oRowAddress;
    end

    // ---------------- stimulus ----------------
    // Predicts the whole request outcome from the plan, then hands it over.
    task automatic issueRequest(input logic [c_WAYS-1:0] way, input logic [23:0] row, input logic enh);
        res_t       r;
        cmd_t       c;
        logic [7:0] s;
        int         polls;
        s = 8'h00; polls = 0;
        r.fail = 1'b0; r.timeout = 1'b0;
        c.way = way; c.row = row; c.tgt = {c_TGT_ID[4:1], enh};
        for (int i = 0; i < plan.size(); i++) begin
            s = (plan[i].nBeats == 0) ? 8'h00 : plan[i].b0;
            cmdQ.push_back(c);
            respQ.push_back(plan[i]);
            polls = i + 1;
            if (isReady(s)) begin
                r.fail = s[0]; r.timeout = 1'b0;
                break;
            end
            if (polls == c_MAX_POLLS) begin
                r.fail = 1'b0; r.timeout = 1'b1;
                break;
            end
        end
        r.way = way; r.status = s; r.count = 8'(polls);
        resQ.push_back(r);
        bus.iPollValid      = 1'b1;
        bus.iPollWay        = way;
        bus.iPollRowAddress = row;
        bus.iPollEnhanced   = enh;
        @(posedge iSystemClock); #1;
        bus.iPollValid = 1'b0;
    endtask

    task automatic waitDone();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge iSystemClock); #1;
            bus.iPollValid = 1'b0;
            if (bus.oPollReady) begin
                done = 1'b1;
                break;
            end
            if (!bus.oResultValid && ($urandom_range(0, 7) == 0)) begin
                bus.iPollValid      = 1'b1;
                bus.iPollWay        = 4'(1 << $urandom_range(0, c_WAYS - 1));
                bus.iPollRowAddress = 24'($urandom);
            end
        end
        if (!done) begin
            nChecks++; nFails++;
            $display("FAIL request_done: got busy after 3000 cycles, expected idle");
        end
    endtask

    task automatic runRequest(input logic [c_WAYS-1:0] way, input logic [23:0] row, input logic enh);
        issueRequest(way, row, enh);
        waitDone();
    endtask

    initial begin : stimulus
        int base;
        bit seen;
        bus.iPollValid      = 1'b0;
        bus.iPollWay        = '0;
        bus.iPollRowAddress = 24'd0;
        bus.iPollEnhanced   = 1'b0;
        iReset = 1'b1;
        repeat (3) @(posedge iSystemClock);
        @(negedge iSystemClock);
        check("rst_poll_ready",  32'(bus.oPollReady), 32'd1);
        check("rst_cmd_valid",   32'(bus.oCMDValid), 32'd0);
        check("rst_read_ready",  32'(bus.oReadReady), 32'd0);
        check("rst_result",      32'(bus.oResultValid), 32'd0);
        check("rst_fail",        32'(bus.oResultFail), 32'd0);
        check("rst_timeout",     32'(bus.oResultTimeout), 32'd0);
        check("rst_status",      32'(bus.oStatus), 32'd0);
        check("rst_count",       32'(bus.oPollCount), 32'd0);
        check("rst_way",         32'(bus.oWaySelect), 32'd0);
        check("rst_row",         32'(bus.oRowAddress), 32'd0);
        check("rst_result_way",  32'(bus.oResultWay), 32'd0);
        check("rst_opcode",      32'(bus.oOpcode), 32'(c_CMD_ID));
        check("rst_target",      32'(bus.oTargetID), 32'({c_TGT_ID[4:1], 1'b0}));
        @(posedge iSystemClock); #1;
        iReset = 1'b0;
        @(posedge iSystemClock); #1;

        // 70h, ready on first poll
        plan = {};
        plan.push_back(mk(1, 8'hE0, 8'h00, 0, 2, 1'b0));
        runRequest(4'b0010, 24'h000000, 1'b0);

        // 78h, two busy polls then ready with fail
        plan = {};
        plan.push_back(mk(1, 8'h80, 8'h00, 1, 1, 1'b0));
        plan.push_back(mk(1, 8'h80, 8'h00, 0, 3, 1'b1));
        plan.push_back(mk(1, 8'hC1, 8'h00, 2, 0, 1'b0));
        runRequest(4'b0001, 24'h123456, 1'b1);

        // never ready -> timeout
        plan = {};
        for (int i = 0; i < c_MAX_POLLS; i++) plan.push_back(mk(1, 8'h80, 8'h00, 0, 1, 1'b0));
        runRequest(4'b1000, 24'h00ABCD, 1'b0);

        // no beat, then two beats where only the first counts
        plan = {};
        plan.push_back(mk(0, 8'h00, 8'h00, 0, 2, 1'b0));
        plan.push_back(mk(2, 8'hE0, 8'h00, 0, 1, 1'b1));
        runRequest(4'b0100, 24'h000010, 1'b0);

        // long command stall
        plan = {};
        plan.push_back(mk(1, 8'hE0, 8'h00, 10, 1, 1'b0));
        runRequest(4'b0010, 24'h654321, 1'b1);

        // ARDY sensitivity
        plan = {};
        plan.push_back(mk(1, 8'hC0, 8'h00, 0, 1, 1'b0));
        plan.push_back(mk(1, 8'hE0, 8'h00, 0, 1, 1'b0));
        runRequest(4'b0001, 24'h000777, 1'b0);

        // reset while in GAP aborts without a result
        plan = {};
        for (int i = 0; i < c_MAX_POLLS; i++) plan.push_back(mk(1, 8'h80, 8'h00, 0, 1, 1'b0));
        base = lastStepSeen;
        issueRequest(4'b0100, 24'h0F0F0F, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge iSystemClock); #1;
            if (lastStepSeen > base) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            nChecks++; nFails++;
            $display("FAIL gap_reset_wait: got no iLastStep in 500 cycles, expected one");
        end
        @(posedge iSystemClock); #1;
        iReset = 1'b1;
        respQ = {}; cmdQ = {}; resQ = {};
        @(posedge iSystemClock); #1;
        iReset = 1'b0;
        @(negedge iSystemClock);
        check("gap_rst_poll_ready", 32'(bus.oPollReady), 32'd1);
        check("gap_rst_cmd_valid",  32'(bus.oCMDValid), 32'd0);
        check("gap_rst_result",     32'(bus.oResultValid), 32'd0);
        check("gap_rst_count",      32'(bus.oPollCount), 32'd0);
        check("gap_rst_status",     32'(bus.oStatus), 32'd0);
        repeat (20) @(posedge iSystemClock);
        #1;

        // randomized requests
        for (int n = 0; n < 30; n++) begin
            plan = {};
            for (int i = 0; i < c_MAX_POLLS; i++) begin
                logic [7:0] st;
                st = 8'($urandom);
                if ($urandom_range(0, 2) != 0) st[6] = 1'b0;
                plan.push_back(mk($urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, 2)),
                                  st, 8'($urandom), $urandom_range(0, 3),
                                  $urandom_range(0, 4), 1'($urandom)));
            end
            runRequest(4'(1 << $urandom_range(0, c_WAYS - 1)), 24'($urandom), 1'($urandom));
        end

        repeat (5) @(posedge iSystemClock);
        if (resQ.size() != 0) begin
            nChecks++; nFails++;
            $display("FAIL results_pending: got %0d outstanding, expected 0", resQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
